// File: rtl/padder_200_pkg.sv
// Shared constants and state encoding for the keccak-f[200] input padder.
package padder_200_pkg;

  localparam int RATE_BYTES = 12;
  localparam int RATE_BITS  = 8 * RATE_BYTES;

  localparam logic [7:0] PAD_FINAL = 8'h80;

  localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
  localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;

  typedef enum logic [1:0] {
    ABSORB,
    PAD_EXTRA,
    LAST_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/padder_200_fill.sv
// Pad-byte vector and slot mask for a final block whose first n slots hold data.
module padder_200_fill
  import padder_200_pkg::*;
#(
  parameter logic [7:0] SUFFIX = SUFFIX_KECCAK
) (
  input  logic [3:0]           n,
  output logic [RATE_BITS-1:0] pad,
  output logic [RATE_BITS-1:0] mask
);

  // Slots at or beyond n are owned by padding; n == RATE_BYTES means a pure data block.
  always_comb begin
    pad  = '0;
    mask = '0;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (k == int'(n)) pad[RATE_BITS-1-8*k -: 8] = SUFFIX;
      if (k >= int'(n)) mask[RATE_BITS-1-8*k -: 8] = 8'hFF;
    end
    if (int'(n) < RATE_BYTES) pad[7:0] = pad[7:0] | PAD_FINAL;
  end

endmodule

// File: rtl/padder_200.sv
// Byte-stream collector and multi-rate padder feeding the keccak-f[200] permutation.
module padder_200
  import padder_200_pkg::*;
#(
  parameter logic [7:0] SUFFIX = SUFFIX_KECCAK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in,
  input  logic                 byte_valid,
  input  logic                 in_ready,
  input  logic                 is_last,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack,
  output logic                 done
);

  state_t               state;
  logic [3:0]           count;
  logic [3:0]           n;
  logic [RATE_BITS-1:0] merged;
  logic [RATE_BITS-1:0] pad;
  logic [RATE_BITS-1:0] mask;

  assign n           = count + {3'b000, byte_valid};
  assign buffer_full = out_ready;

  padder_200_fill #(.SUFFIX(SUFFIX)) u_fill (
    .n    (n),
    .pad  (pad),
    .mask (mask)
  );

  // The block register doubles as the collection buffer; the incoming byte lands in slot count.
  always_comb begin
    merged = out;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (byte_valid && (k == int'(count))) merged[RATE_BITS-1-8*k -: 8] = in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ABSORB;
      count     <= '0;
      out       <= '0;
      out_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ABSORB: begin
          if (out_ready) begin
            if (f_ack) begin
              out_ready <= 1'b0;
              out       <= '0;
              count     <= '0;
            end
          end else if (in_ready) begin
            if (is_last) begin
              out       <= (merged & ~mask) | pad;
              out_ready <= 1'b1;
              count     <= '0;
              state     <= (n == 4'(RATE_BYTES)) ? PAD_EXTRA : LAST_WAIT;
            end else if (byte_valid) begin
              out <= merged;
              if (count == 4'(RATE_BYTES - 1)) begin
                count     <= '0;
                out_ready <= 1'b1;
              end else begin
                count <= count + 4'd1;
              end
            end
          end
        end
        // Message ended exactly on a block boundary: padding needs a whole block of its own.
        PAD_EXTRA: begin
          if (f_ack) begin
            out   <= {SUFFIX, 80'h0, PAD_FINAL};
            state <= LAST_WAIT;
          end
        end
        LAST_WAIT: begin
          if (f_ack) begin
            out_ready <= 1'b0;
            out       <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padder_200.sv
// Randomized self-checking bench for padder_200 against a padded-message block model.
module tb_padder_200;

  localparam int RATE       = 12;
  localparam int MAX_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in;
  logic        byte_valid;
  logic        in_ready;
  logic        is_last;
  logic        buffer_full;
  logic [95:0] out;
  logic        out_ready;
  logic        f_ack;
  logic        done;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0]  msg_q[$];
  logic [95:0] exp_q[$];

  padder_200 #(.SUFFIX(8'h01)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .byte_valid  (byte_valid),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic bv, input logic il,
                               input logic [7:0] d, input logic ack);
    in_ready   = ir;
    byte_valid = bv;
    is_last    = il;
    in         = d;
    f_ack      = ack;
  endtask

  // Message, then SUFFIX, zero-fill to a whole number of blocks, final byte OR 0x80.
  function automatic void build_blocks();
    logic [7:0]  p[$];
    logic [95:0] blk;
    p = msg_q;
    p.push_back(8'h01);
    while (p.size() % RATE != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    exp_q.delete();
    for (int b = 0; b < p.size() / RATE; b++) begin
      blk = '0;
      for (int k = 0; k < RATE; k++) blk = {blk[87:0], p[b*RATE+k]};
      exp_q.push_back(blk);
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out", out, 96'h0);
    checkOutput("rst_out_ready", 96'(out_ready), 96'h0);
    checkOutput("rst_buffer_full", 96'(buffer_full), 96'h0);
    checkOutput("rst_done", 96'(done), 96'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_message(input bit last_alone, input int ack_delay, input bit dense, input int abort_after);
    int sz, items, idx, blk, wait_cnt, cycles, bytes_acc, avail;
    bit last_acc, exp_ready, exp_done, offer, ack, finished;
    build_blocks();
    sz = msg_q.size();
    items = sz + (last_alone ? 1 : 0);
    idx = 0; blk = 0; wait_cnt = 0; cycles = 0; bytes_acc = 0;
    last_acc = 0; finished = 0;
    while (!finished) begin
      @(negedge clk);
      avail     = last_acc ? exp_q.size() : bytes_acc / RATE;
      exp_ready = (blk < avail);
      exp_done  = last_acc && (blk == exp_q.size());
      checkOutput("out_ready", 96'(out_ready), 96'(exp_ready));
      checkOutput("buffer_full", 96'(buffer_full), 96'(exp_ready));
      checkOutput("done", 96'(done), 96'(exp_done));
      if (exp_ready) checkOutput($sformatf("out_blk%0d", blk), out, exp_q[blk]);
      if (exp_done || cycles >= MAX_CYCLES || (abort_after >= 0 && idx >= abort_after)) begin
        finished = 1;
      end else begin
        offer = (idx < items) && (dense || $urandom_range(0, 3) != 0);
        ack = 1'b0;
        if (exp_ready) begin
          if (wait_cnt >= ack_delay) begin
            ack = 1'b1; blk++; wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          ack = ($urandom_range(0, 4) == 0);
        end
        if (offer) begin
          if (idx < sz) applyStimulus(1'b1, 1'b1, !last_alone && (idx == sz - 1), msg_q[idx], ack);
          else applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), ack);
          if (!exp_ready) begin
            if (idx < sz) bytes_acc++;
            if (idx == items - 1) last_acc = 1;
            idx++;
          end
        end else begin
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ack);
        end
        cycles++;
      end
    end
    if (abort_after < 0) begin
      checkOutput("blocks_acked", 96'(blk), 96'(exp_q.size()));
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 1)));
        @(negedge clk);
        checkOutput("idle_done", 96'(done), 96'h1);
        checkOutput("idle_out_ready", 96'(out_ready), 96'h0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int len;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    reset_dut();
    msg_q.delete();
    run_message(1'b1, 0, 1'b1, -1);

    reset_dut();
    msg_q = '{8'hAA, 8'hBB, 8'hCC};
    run_message(1'b0, 2, 1'b0, -1);

    reset_dut();
    msg_q.delete();
    for (int i = 0; i < 11; i++) msg_q.push_back(8'(i));
    run_message(1'b0, 1, 1'b1, -1);

    reset_dut();
    msg_q.delete();
    for (int i = 0; i < 12; i++) msg_q.push_back(8'(i));
    run_message(1'b0, 3, 1'b1, -1);

    reset_dut();
    msg_q.delete();
    for (int i = 0; i < 30; i++) msg_q.push_back(8'($urandom));
    run_message(1'b0, 16, 1'b1, -1);

    reset_dut();
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
    run_message(1'b0, 0, 1'b1, 5);
    reset_dut();
    msg_q = '{8'h11, 8'h22};
    run_message(1'b0, 1, 1'b1, -1);

    for (int t = 0; t < 10; t++) begin
      reset_dut();
      msg_q.delete();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_message((len == 0) || ($urandom_range(0, 1) == 1), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/padder_200.md
Name: padder_200

Overview:
- Upstream stage of the keccak-f[200] sponge (rate 96 bits = 12 bytes).
- Collects a byte stream into 96-bit blocks and appends multi-rate padding (domain suffix byte, zeros, final bit 0x80).
- Presents each block to the permutation through out/out_ready, and holds it until the permutation's ack pulse.

Parameters:
SUFFIX, 8'h01, domain-separation/first pad byte (8'h06 SHA3, 8'h1F SHAKE); bit 7 must be 0.
RATE_BYTES, 12, fixed localparam (not overridable); block size in bytes.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in  input  8  message byte
byte_valid  input  1  in carries a data byte (qualifies in when in_ready=1)
in_ready  input  1  source offers an item this cycle (data byte and/or is_last)
is_last  input  1  item is the message end; with byte_valid=0 it means end with no byte
buffer_full  output  1  stall: upstream items are ignored while 1
out  output  96  block to permutation, first byte in out[95:88]
out_ready  output  1  out holds a complete block
f_ack  input  1  one-cycle pulse from permutation: current block consumed
done  output  1  final padded block has been acked; sticky until rst

Behaviour:
- Reset (rst=1 at clk edge): out=0, out_ready=0, buffer_full=0, done=0, byte count=0, state=ABSORB. Reset mid-block discards partial data.
- buffer_full == out_ready, both registered.
- accept = in_ready & ~buffer_full & (state==ABSORB). Items offered while not accepted are dropped; the source must hold them.
- States: ABSORB, PAD_EXTRA, LAST_WAIT, DONE.
- ABSORB, accept & byte_valid & ~is_last:
  - Byte goes to slot count; count++.
  - If count reaches 12: buffer_full=1 next cycle, count=0.
- ABSORB, accept & is_last:
  - n = count + byte_valid (data byte, if any, written to slot count).
  - If n<12: in the same cycle, slot n=SUFFIX, slots n+1..11=0, then slot 11 |= 0x80. If n==11, slot 11=SUFFIX|0x80. buffer_full=1 next cycle; state->LAST_WAIT.
  - If n==12: block is data only; buffer_full=1; state->PAD_EXTRA.
- Slot k occupies out[95-8k -: 8].
- f_ack while buffer_full:
  - Next cycle: out_ready=0, out=0, count=0.
  - Exception, PAD_EXTRA: out loaded with {SUFFIX, 80'h0, 8'h80}, out_ready stays 1, state->LAST_WAIT.
  - LAST_WAIT: ->DONE, done=1.
- f_ack while ~buffer_full: ignored.
- f_ack and in_ready in the same cycle while full: the ack is processed and the input is not accepted (accept is already blocked by buffer_full).
- DONE: all inputs ignored, out_ready=0 until rst.
- out is stable whenever out_ready=1. Latency from accepting the 12th byte (or is_last) to out_ready: 1 cycle.
- Each block reaches out_ready exactly once. The permutation's own gating (no new accept while it computes) keeps its in_ready=out_ready safe, provided ack clears out_ready before the permutation can re-accept.

Decomposition:
- Shared package/header: RATE_BYTES=12, RATE_BITS=96, pad-final constant 8'h80, state encodings, standard SUFFIX values (KECCAK 8'h01, SHA3 8'h06, SHAKE 8'h1F).
- One natural sub-module: padder_200_fill. It is combinational: given the count n and SUFFIX, it produces the 12-slot pad-byte vector and the byte-select mask used on the is_last cycle.
- The FSM, counter and buffer stay in the top module.

Test Plan:
- Empty message (SUFFIX=01): single item is_last=1, byte_valid=0 -> next cycle out=96'h01000000_00000000_00000080, out_ready=1; pulse f_ack -> done=1, out_ready=0.
- 3 bytes AA,BB,CC, last on CC -> out=96'hAABBCC01_00000000_00000080; one block only.
- 11 bytes 00..0A, last on 0A -> out=96'h00010203_04050607_08090A81 (merged 0x81).
- 12 bytes 00..0B, last on 0B -> first out=96'h00010203_04050607_08090A0B, done=0. After f_ack -> second out=96'h01000000_00000000_00000080, out_ready held 1. After second f_ack -> done=1.
- 30-byte stream with f_ack delayed 16 cycles per block:
  - in_ready held during buffer_full -> no bytes lost or duplicated.
  - Three blocks total: 12 data, 12 data, then 6 data + 01 ... 80.
  - out is stable throughout each out_ready window.
- rst=1 asserted after 5 bytes, then 2 bytes 11,22 with is_last=1 on the 22 -> out=96'h11220100_00000000_00000080. No trace of the earlier bytes; all outputs 0 during rst.
